// File: rtl/mux_tree_pkg.sv
// Shared constants and elaboration helpers for the pipelined N:1 mux tree.
package mux_tree_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// One registered 2:1 reduction level: halves the word count using select bit LEVEL
// and carries the full select and valid bit forward.
module mux_tree_stage
    import mux_tree_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int N_IN  = 8,
    parameter int SEL_W = 3,
    parameter int LEVEL = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        in_valid,
    input  logic [SEL_W-1:0]            in_sel,
    input  logic [N_IN*WIDTH-1:0]       in_data,
    output logic                        out_valid,
    output logic [SEL_W-1:0]            out_sel,
    output logic [(N_IN/2)*WIDTH-1:0]   out_data
);

    localparam int N_OUT = N_IN / 2;

    logic [N_OUT*WIDTH-1:0] reduced;

    // NOTE: default first so every bit is assigned on every path and no latch is inferred.
    always_comb begin
        reduced = '0;
        for (int j = 0; j < N_OUT; j++) begin
            reduced[j*WIDTH +: WIDTH] = in_sel[LEVEL] ? in_data[(2*j+1)*WIDTH +: WIDTH]
                                                      : in_data[(2*j)*WIDTH +: WIDTH];
        end
    end

    // NOTE: non-blocking assignments so every stage samples its neighbour's pre-edge value.
    // Data/sel only move on a valid sample, so bubbles leave the last result visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sel   <= '0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_sel  <= in_sel;
                out_data <= reduced;
            end
        end
    end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 mux tree: entry select (manual or round-robin scan), scan counter,
// and one registered reduction stage per select bit.
module mux_tree_pipe
    import mux_tree_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      in_valid,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      scan_clr,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic [SEL_W-1:0]          scan_idx
);

    if (!is_pow2(CHANNELS)) begin : g_bad_channels
        $error("mux_tree_pipe: CHANNELS must be a power of two and >= 2");
    end
    if (SEL_W != $clog2(CHANNELS)) begin : g_bad_sel_w
        $error("mux_tree_pipe: SEL_W is derived from CHANNELS and must not be overridden");
    end

    logic [SEL_W-1:0] scan_cnt;
    logic [SEL_W-1:0] eff_sel;

    // The entering sample sees the pre-clear count even when scan_clr is asserted.
    assign eff_sel  = (mode == MODE_SCAN) ? scan_cnt : sel;
    assign scan_idx = scan_cnt;

    // Clear wins over advance and ignores en; the power-of-two width makes +1 wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || scan_clr) begin
            scan_cnt <= '0;
        end else if (en && in_valid && (mode == MODE_SCAN)) begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
        localparam int N_IN = CHANNELS >> k;

        logic                      v;
        logic [SEL_W-1:0]          s;
        logic [(N_IN/2)*WIDTH-1:0] d;

        if (k == 0) begin : g_entry
            mux_tree_stage #(
                .WIDTH (WIDTH),
                .N_IN  (N_IN),
                .SEL_W (SEL_W),
                .LEVEL (k)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .en        (en),
                .in_valid  (in_valid),
                .in_sel    (eff_sel),
                .in_data   (data_in),
                .out_valid (v),
                .out_sel   (s),
                .out_data  (d)
            );
        end else begin : g_inner
            mux_tree_stage #(
                .WIDTH (WIDTH),
                .N_IN  (N_IN),
                .SEL_W (SEL_W),
                .LEVEL (k)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .en        (en),
                .in_valid  (g_lvl[k-1].v),
                .in_sel    (g_lvl[k-1].s),
                .in_data   (g_lvl[k-1].d),
                .out_valid (v),
                .out_sel   (s),
                .out_data  (d)
            );
        end
    end

    assign out_valid = g_lvl[SEL_W-1].v;
    assign out_sel   = g_lvl[SEL_W-1].s;
    assign out_data  = g_lvl[SEL_W-1].d;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Scoreboard bench for mux_tree_pipe (CHANNELS=8, WIDTH=4, channel i carries i+1).
module tb_mux_tree_pipe;

    localparam int WIDTH    = 4;
    localparam int CHANNELS = 8;
    localparam int SEL_W    = 3;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [SEL_W-1:0] s;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      en;
    logic                      in_valid;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic                      scan_clr;
    logic [CHANNELS*WIDTH-1:0] data_in;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_sel;
    logic [SEL_W-1:0]          scan_idx;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    logic last_en  = 1'b0;

    mux_tree_pipe #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .mode      (mode),
        .sel       (sel),
        .scan_clr  (scan_clr),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .scan_idx  (scan_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one sample for one cycle and records the hand-derived channel it must produce.
    task automatic issue(input logic m, input logic [SEL_W-1:0] s, input logic [SEL_W-1:0] exp_sel);
        exp_t e;
        in_valid = 1'b1;
        mode     = m;
        sel      = s;
        e.s      = exp_sel;
        e.d      = WIDTH'(exp_sel) + 4'd1;
        sb_q.push_back(e);
        tick();
    endtask

    // A new result exists only after an enabled edge; stalled cycles repeat the old one.
    always @(posedge clk) last_en = en;

    always @(negedge clk) begin
        if (last_en && out_valid) begin
            if (sb_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL sb_unexpected: got out_sel=%0d out_data=%0d, expected no output", out_sel, out_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_out_sel", 32'(out_sel), 32'(e.s));
                check("sb_out_data", 32'(out_data), 32'(e.d));
            end
        end
    end

    logic [SEL_W-1:0] scan_tbl [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};

    initial begin
        rst      = 1'b1;
        en       = 1'b1;
        in_valid = 1'b0;
        mode     = 1'b0;
        sel      = '0;
        scan_clr = 1'b0;
        for (int i = 0; i < CHANNELS; i++) data_in[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
        tick(2);
        rst = 1'b0;

        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data",  32'(out_data),  0);
        check("rst_out_sel",   32'(out_sel),   0);
        check("rst_scan_idx",  32'(scan_idx),  0);

        // Single manual sample: visible after 3 edges, then held under out_valid=0.
        issue(1'b0, 3'd5, 3'd5);
        in_valid = 1'b0;
        tick(2);
        check("man_valid", 32'(out_valid), 1);
        tick();
        check("man_bubble_valid", 32'(out_valid), 0);
        check("man_hold_data",    32'(out_data),  6);
        check("man_hold_sel",     32'(out_sel),   5);

        // Back-to-back manual selects 0..7.
        for (int i = 0; i < CHANNELS; i++) issue(1'b0, 3'(i), 3'(i));
        in_valid = 1'b0;
        check("b2b_mid_valid", 32'(out_valid), 1);
        check("b2b_mid_sel",   32'(out_sel),   5);
        tick(2);
        check("b2b_last_valid", 32'(out_valid), 1);
        check("b2b_last_sel",   32'(out_sel),   7);
        check("b2b_last_data",  32'(out_data),  8);
        check("b2b_scan_hold",  32'(scan_idx),  0);
        tick();
        check("b2b_end_valid", 32'(out_valid), 0);

        // Auto-scan for 10 samples wraps 7 -> 0; manual sel is ignored.
        for (int i = 0; i < 10; i++) issue(1'b1, 3'd6, scan_tbl[i]);
        in_valid = 1'b0;
        check("scan_idx_after10", 32'(scan_idx), 2);
        tick(4);

        // Scan clear: accepted sample uses pre-clear value 4.
        issue(1'b1, 3'd0, 3'd2);
        issue(1'b1, 3'd0, 3'd3);
        check("scan_idx_pre_clr", 32'(scan_idx), 4);
        scan_clr = 1'b1;
        issue(1'b1, 3'd0, 3'd4);
        scan_clr = 1'b0;
        check("scan_idx_cleared", 32'(scan_idx), 0);
        issue(1'b1, 3'd0, 3'd0);
        in_valid = 1'b0;
        check("scan_idx_post_clr", 32'(scan_idx), 1);
        tick(4);

        // Stall for 2 cycles mid-stream; blocked in_valid must not be accepted.
        issue(1'b0, 3'd1, 3'd1);
        issue(1'b0, 3'd2, 3'd2);
        issue(1'b0, 3'd3, 3'd3);
        check("stall_pre_sel", 32'(out_sel), 1);
        en       = 1'b0;
        in_valid = 1'b1;
        sel      = 3'd7;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_valid", 32'(out_valid), 1);
            check("stall_sel",   32'(out_sel),   1);
            check("stall_data",  32'(out_data),  2);
            check("stall_scan",  32'(scan_idx),  1);
        end
        en = 1'b1;
        issue(1'b0, 3'd4, 3'd4);
        in_valid = 1'b0;
        check("stall_resume_sel", 32'(out_sel), 2);
        tick();
        check("stall_c_sel", 32'(out_sel), 3);
        tick();
        check("stall_d_sel",  32'(out_sel),  4);
        check("stall_d_data", 32'(out_data), 5);
        tick(2);

        // Reset with two samples in flight.
        issue(1'b0, 3'd6, 3'd6);
        issue(1'b0, 3'd7, 3'd7);
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        sb_q.delete();
        rst = 1'b0;
        check("mrst_valid", 32'(out_valid), 0);
        check("mrst_data",  32'(out_data),  0);
        check("mrst_sel",   32'(out_sel),   0);
        check("mrst_scan",  32'(scan_idx),  0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mrst_no_stale", 32'(out_valid), 0);
        end

        tick(2);
        check("sb_drained", 32'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
